pc_seq_unit: RTL and testbench

PC_SEQ_UNIT -- requirements
Module: pc_seq_unit

---
 rtl/pc_seq_unit.sv | 134 +++++++++++++
 tb/tb_pc_seq_unit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_seq_unit.sv
// pc_seq_unit: program-counter sequencer with halt/resume FSM, a saturating
// taken-branch counter and a first-word-fall-through branch-trace FIFO.
module pc_seq_unit #(
  parameter int unsigned       ADDR_W      = 64,
  parameter int unsigned       STRIDE      = 3,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int unsigned       TRACE_DEPTH = 8,
  parameter int unsigned       CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              upd_valid,
  input  logic              pc_ld,
  input  logic [ADDR_W-1:0] c,
  input  logic              resume,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic [CNT_W-1:0]  jump_cnt,
  output logic              trace_valid,
  input  logic              trace_ready,
  output logic [ADDR_W-1:0] trace_from,
  output logic [ADDR_W-1:0] trace_to,
  output logic              trace_ovf
);

  localparam int unsigned PTR_W = $clog2(TRACE_DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(TRACE_DEPTH);

  typedef enum logic {RUN, HALTED} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] mem_from [TRACE_DEPTH];
  logic [ADDR_W-1:0] mem_to   [TRACE_DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr, rd_ptr_next, wr_ptr_next;
  logic [OCC_W-1:0]  occ, occ_next, occ_after_pop;
  logic              upd_run, taken, pop, push, drop;
  logic [ADDR_W-1:0] pc_next, head_from_next, head_to_next;
  logic [CNT_W-1:0]  jump_cnt_next;

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst) state <= RUN;
    else      state <= state_next;
  end

  // FSM next state: a negative jump target halts, resume restarts
  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (upd_valid && pc_ld && c[ADDR_W-1]) state_next = HALTED;
      HALTED:  if (resume) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // Datapath next values: PC, branch counter, FIFO pointers and head entry
  always_comb begin
    upd_run        = (state == RUN) && upd_valid;
    taken          = upd_run && pc_ld && !c[ADDR_W-1];
    pop            = trace_valid && trace_ready;
    push           = taken && ((occ < OCC_MAX) || pop);
    drop           = taken && !push;
    pc_next        = pc;
    jump_cnt_next  = jump_cnt;
    rd_ptr_next    = rd_ptr;
    wr_ptr_next    = wr_ptr;
    head_from_next = '0;
    head_to_next   = '0;

    if (state == HALTED) begin
      if (resume) pc_next = RESET_PC;
    end else if (upd_run && !pc_ld) begin
      pc_next = pc + ADDR_W'(STRIDE);
    end else if (taken) begin
      pc_next = c;
    end

    if (taken && (jump_cnt != '1)) jump_cnt_next = jump_cnt + CNT_W'(1);

    if (pop)  rd_ptr_next = rd_ptr + PTR_W'(1);
    if (push) wr_ptr_next = wr_ptr + PTR_W'(1);
    occ_after_pop = occ - OCC_W'(pop);
    occ_next      = occ_after_pop + OCC_W'(push);

    // The new head is either the entry being pushed (FIFO otherwise empty)
    // or an entry already stored at the next read pointer.
    if (occ_next != '0) begin
      if (occ_after_pop == '0) begin
        head_from_next = pc;
        head_to_next   = c;
      end else begin
        head_from_next = mem_from[rd_ptr_next];
        head_to_next   = mem_to[rd_ptr_next];
      end
    end
  end

  // Registered state and outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc          <= RESET_PC;
      halted      <= 1'b0;
      jump_cnt    <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      occ         <= '0;
      trace_valid <= 1'b0;
      trace_from  <= '0;
      trace_to    <= '0;
      trace_ovf   <= 1'b0;
    end else begin
      pc          <= pc_next;
      halted      <= (state_next == HALTED);
      jump_cnt    <= jump_cnt_next;
      rd_ptr      <= rd_ptr_next;
      wr_ptr      <= wr_ptr_next;
      occ         <= occ_next;
      trace_valid <= (occ_next != '0);
      trace_from  <= head_from_next;
      trace_to    <= head_to_next;
      trace_ovf   <= trace_ovf | drop;
    end
  end

  // Trace storage write port
  always_ff @(posedge clk) begin
    if (rst && push) begin
      mem_from[wr_ptr] <= pc;
      mem_to[wr_ptr]   <= c;
    end
  end

endmodule

// File: tb/tb_pc_seq_unit.sv
// tb_pc_seq_unit: directed stimulus with a trace scoreboard checked by a
// separate pop monitor, plus a narrow instance for wrap and saturation.
module tb_pc_seq_unit;

  typedef struct packed {
    logic [63:0] frm;
    logic [63:0] dst;
  } ent_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter instance
  logic        rst, upd_valid, pc_ld, resume, trace_ready;
  logic [63:0] c;
  logic [63:0] pc, trace_from, trace_to;
  logic [15:0] jump_cnt;
  logic        halted, trace_valid, trace_ovf;

  // Narrow instance: 8-bit PC reset to all-ones, 2-bit counter
  logic        b_rst, b_upd_valid, b_pc_ld, b_resume, b_trace_ready;
  logic [7:0]  b_c;
  logic [7:0]  b_pc, b_trace_from, b_trace_to;
  logic [1:0]  b_jump_cnt;
  logic        b_halted, b_trace_valid, b_trace_ovf;

  int   checks = 0;
  int   errors = 0;
  ent_t sb[$];
  ent_t mon_e;

  pc_seq_unit #(.ADDR_W(64), .STRIDE(3), .RESET_PC(64'd0), .TRACE_DEPTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .upd_valid(upd_valid), .pc_ld(pc_ld), .c(c), .resume(resume),
    .pc(pc), .halted(halted), .jump_cnt(jump_cnt), .trace_valid(trace_valid),
    .trace_ready(trace_ready), .trace_from(trace_from), .trace_to(trace_to), .trace_ovf(trace_ovf)
  );

  pc_seq_unit #(.ADDR_W(8), .STRIDE(3), .RESET_PC(8'hFF), .TRACE_DEPTH(2), .CNT_W(2)) dut_b (
    .clk(clk), .rst(b_rst), .upd_valid(b_upd_valid), .pc_ld(b_pc_ld), .c(b_c), .resume(b_resume),
    .pc(b_pc), .halted(b_halted), .jump_cnt(b_jump_cnt), .trace_valid(b_trace_valid),
    .trace_ready(b_trace_ready), .trace_from(b_trace_from), .trace_to(b_trace_to), .trace_ovf(b_trace_ovf)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic ld, input logic [63:0] tgt);
    upd_valid = 1'b1;
    pc_ld     = ld;
    c         = tgt;
    step();
    upd_valid = 1'b0;
    pc_ld     = 1'b0;
    c         = '0;
  endtask

  task automatic expect_entry(input logic [63:0] f, input logic [63:0] t);
    sb.push_back('{frm: f, dst: t});
  endtask

  // Monitor: every pop of the default instance must match the oldest expected entry
  always @(negedge clk) begin
    if (rst && trace_valid && trace_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL trace_pop unexpected from=%0h to=%0h", trace_from, trace_to);
      end else begin
        mon_e = sb.pop_front();
        check("trace_pop_from", trace_from, mon_e.frm);
        check("trace_pop_to", trace_to, mon_e.dst);
      end
    end
  end

  initial begin
    rst = 1'b0; upd_valid = 1'b0; pc_ld = 1'b0; c = '0; resume = 1'b0; trace_ready = 1'b0;
    b_rst = 1'b0; b_upd_valid = 1'b0; b_pc_ld = 1'b0; b_c = '0; b_resume = 1'b0; b_trace_ready = 1'b1;
    step();
    step();
    rst = 1'b1;
    b_rst = 1'b1;

    // Reset state
    check("rst_pc", pc, 64'd0);
    check("rst_halted", 64'(halted), 64'd0);
    check("rst_jump_cnt", 64'(jump_cnt), 64'd0);
    check("rst_trace_valid", 64'(trace_valid), 64'd0);
    check("rst_trace_from", trace_from, 64'd0);
    check("rst_trace_to", trace_to, 64'd0);
    check("rst_trace_ovf", 64'(trace_ovf), 64'd0);

    // Sequential PC
    upd(1'b0, '0); check("seq_pc1", pc, 64'd3);
    upd(1'b0, '0); check("seq_pc2", pc, 64'd6);
    upd(1'b0, '0); check("seq_pc3", pc, 64'd9);
    step();        check("hold_pc", pc, 64'd9);
    check("seq_trace_valid", 64'(trace_valid), 64'd0);
    check("seq_jump_cnt", 64'(jump_cnt), 64'd0);

    // Branch and trace
    upd(1'b1, 64'd40);
    expect_entry(64'd9, 64'd40);
    check("br_pc", pc, 64'd40);
    check("br_jump_cnt", 64'(jump_cnt), 64'd1);
    check("br_trace_valid", 64'(trace_valid), 64'd1);
    check("br_trace_from", trace_from, 64'd9);
    check("br_trace_to", trace_to, 64'd40);
    trace_ready = 1'b1;
    step();
    trace_ready = 1'b0;
    check("br_pop_valid", 64'(trace_valid), 64'd0);

    // Halt and resume
    upd(1'b1, '1);
    check("halt_halted", 64'(halted), 64'd1);
    check("halt_pc", pc, 64'd40);
    check("halt_trace_valid", 64'(trace_valid), 64'd0);
    upd(1'b0, '0);
    upd(1'b1, 64'd100);
    check("halted_ignore_pc", pc, 64'd40);
    check("halted_ignore_cnt", 64'(jump_cnt), 64'd1);
    check("halted_stays", 64'(halted), 64'd1);
    resume = 1'b1;
    step();
    resume = 1'b0;
    check("resume_pc", pc, 64'd0);
    check("resume_halted", 64'(halted), 64'd0);
    resume = 1'b1;
    upd(1'b0, '0);
    resume = 1'b0;
    check("resume_in_run_ignored", pc, 64'd3);

    // Overflow: nine taken branches into an undrained 8-entry FIFO
    for (int i = 0; i < 9; i++) begin
      logic [63:0] frm;
      logic [63:0] tgt;
      tgt = 64'(100 + 10 * i);
      frm = (i == 0) ? 64'd3 : 64'(100 + 10 * (i - 1));
      upd(1'b1, tgt);
      if (i < 8) expect_entry(frm, tgt);
    end
    check("ovf_flag", 64'(trace_ovf), 64'd1);
    check("ovf_jump_cnt", 64'(jump_cnt), 64'd10);
    check("ovf_pc", pc, 64'd180);

    // Halt/resume with a full FIFO keeps counter, flag and contents
    upd(1'b1, 64'h8000_0000_0000_0000);
    check("ovf_halted", 64'(halted), 64'd1);
    resume = 1'b1;
    step();
    resume = 1'b0;
    check("resume2_pc", pc, 64'd0);
    check("resume2_jump_cnt", 64'(jump_cnt), 64'd10);
    check("resume2_ovf", 64'(trace_ovf), 64'd1);
    check("resume2_valid", 64'(trace_valid), 64'd1);
    check("resume2_head_from", trace_from, 64'd3);
    check("resume2_head_to", trace_to, 64'd100);

    // Push and pop together while full: occupancy stays 8, new entry at tail
    trace_ready = 1'b1;
    upd(1'b1, 64'd200);
    expect_entry(64'd0, 64'd200);
    check("full_pp_jump_cnt", 64'(jump_cnt), 64'd11);
    for (int i = 0; i < 7; i++) step();
    check("drain7_valid", 64'(trace_valid), 64'd1);
    check("drain7_head_from", trace_from, 64'd0);
    check("drain7_head_to", trace_to, 64'd200);
    step();
    check("drain8_valid", 64'(trace_valid), 64'd0);
    step();
    check("empty_ready_valid", 64'(trace_valid), 64'd0);
    check("empty_ready_from", trace_from, 64'd0);
    check("empty_ready_to", trace_to, 64'd0);
    check("empty_ready_ovf", 64'(trace_ovf), 64'd1);
    trace_ready = 1'b0;
    check("sb_drained", 64'(sb.size()), 64'd0);

    // Reset mid-operation with three entries and a pending taken branch
    upd(1'b1, 64'd300);
    upd(1'b1, 64'd310);
    upd(1'b1, 64'd320);
    check("pre_rst_jump_cnt", 64'(jump_cnt), 64'd14);
    rst = 1'b0; upd_valid = 1'b1; pc_ld = 1'b1; c = 64'd330; trace_ready = 1'b1; resume = 1'b1;
    step();
    rst = 1'b1; upd_valid = 1'b0; pc_ld = 1'b0; c = '0; trace_ready = 1'b0; resume = 1'b0;
    check("midrst_pc", pc, 64'd0);
    check("midrst_valid", 64'(trace_valid), 64'd0);
    check("midrst_from", trace_from, 64'd0);
    check("midrst_to", trace_to, 64'd0);
    check("midrst_jump_cnt", 64'(jump_cnt), 64'd0);
    check("midrst_ovf", 64'(trace_ovf), 64'd0);
    check("midrst_halted", 64'(halted), 64'd0);
    upd(1'b0, '0);
    check("post_rst_first_upd", pc, 64'd3);

    // Narrow instance: PC wrap and counter saturation
    check("b_rst_pc", 64'(b_pc), 64'hFF);
    b_upd_valid = 1'b1; b_pc_ld = 1'b0;
    step();
    check("b_wrap_pc", 64'(b_pc), 64'd2);
    for (int i = 0; i < 5; i++) begin
      b_pc_ld = 1'b1;
      b_c = 8'(10 * (i + 1));
      step();
      check("b_sat_cnt", 64'(b_jump_cnt), (i < 3) ? 64'(i + 1) : 64'd3);
    end
    b_upd_valid = 1'b0; b_pc_ld = 1'b0; b_c = '0;
    check("b_pc_final", 64'(b_pc), 64'd50);
    check("b_ovf", 64'(b_trace_ovf), 64'd0);
    check("b_head_from", 64'(b_trace_from), 64'd40);
    check("b_head_to", 64'(b_trace_to), 64'd50);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
